// File: rtl/hazard_detection_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : hazard_detection_unit
// Brief    : ID-stage hazard control for the 5-stage RISC-V pipeline.
//            Resolves load-use stalls, data-memory wait freezes (with timeout)
//            and taken-branch flushes. Optional stall performance counters
//            are built only when HAZARD_PERF_EN is defined; otherwise the
//            counter outputs are tied to zero.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module hazard_detection_unit #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       Rs1_ID,
  input  logic [4:0]       Rs2_ID,
  input  logic             Uses_rs1_ID,
  input  logic             Uses_rs2_ID,
  input  logic [4:0]       Rd_EX,
  input  logic             MemRead_EX,
  input  logic             Branch_taken_EX,
  input  logic             MemReq_MEM,
  input  logic             Mem_ready,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             EXMEMWrite,
  output logic             Bubble_IDEX,
  output logic             Flush_IFID,
  output logic             Mem_timeout,
  output logic [CNT_W-1:0] Load_use_cnt,
  output logic [CNT_W-1:0] Mem_wait_cnt,
  output logic [CNT_W-1:0] Flush_cnt
);

  // Wait counter must be able to hold MEM_TIMEOUT itself.
  localparam int c_WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_WAIT_W-1:0] c_TIMEOUT = c_WAIT_W'(MEM_TIMEOUT);
  localparam logic [c_WAIT_W-1:0] c_ONE     = c_WAIT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                r_mem_timeout;

  logic w_mem_stall;
  logic w_freeze;
  logic w_load_use;
  logic w_do_load_use;
  logic w_do_flush;

  assign w_mem_stall = MemReq_MEM && !Mem_ready;
  assign w_freeze    = w_mem_stall || (r_state == ST_ERROR);

  // x0 never carries a real dependency, and only operands actually read count.
  assign w_load_use = MemRead_EX && (Rd_EX != 5'd0) &&
                      ((Uses_rs1_ID && (Rs1_ID == Rd_EX)) ||
                       (Uses_rs2_ID && (Rs2_ID == Rd_EX)));

  // A branch squashes the ID instruction, so it outranks a load-use match.
  assign w_do_flush    = !w_freeze && Branch_taken_EX;
  assign w_do_load_use = !w_freeze && !Branch_taken_EX && w_load_use;

  // Zero-latency pipeline controls; freeze holds every stage untouched.
  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEXWrite   = 1'b1;
    EXMEMWrite  = 1'b1;
    Bubble_IDEX = 1'b0;
    Flush_IFID  = 1'b0;
    if (w_freeze) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXWrite  = 1'b0;
      EXMEMWrite = 1'b0;
    end else if (w_do_flush) begin
      Flush_IFID  = 1'b1;
      Bubble_IDEX = 1'b1;
    end else if (w_do_load_use) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      Bubble_IDEX = 1'b1;
    end
  end

  // Memory-wait FSM: tracks consecutive wait cycles and latches the timeout error.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_stall) begin
            r_wait_cnt <= c_ONE;
            if (c_ONE >= c_TIMEOUT) begin
              r_state       <= ST_ERROR;
              r_mem_timeout <= 1'b1;
            end else begin
              r_state <= ST_MEM_WAIT;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (!MemReq_MEM || Mem_ready) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_ONE;
            if ((r_wait_cnt + c_ONE) >= c_TIMEOUT) begin
              r_state       <= ST_ERROR;
              r_mem_timeout <= 1'b1;
            end
          end
        end
        ST_ERROR: begin
          r_state       <= ST_ERROR;
          r_mem_timeout <= 1'b1;
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign Mem_timeout = r_mem_timeout;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_load_use_cnt;
  logic [CNT_W-1:0] r_mem_wait_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating event counters, one increment per cycle the hazard is acted on.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_load_use_cnt <= '0;
      r_mem_wait_cnt <= '0;
      r_flush_cnt    <= '0;
    end else begin
      if (w_do_load_use && (r_load_use_cnt != '1))
        r_load_use_cnt <= r_load_use_cnt + 1'b1;
      if (w_freeze && (r_mem_wait_cnt != '1))
        r_mem_wait_cnt <= r_mem_wait_cnt + 1'b1;
      if (w_do_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign Load_use_cnt = r_load_use_cnt;
  assign Mem_wait_cnt = r_mem_wait_cnt;
  assign Flush_cnt    = r_flush_cnt;
`else
  assign Load_use_cnt = '0;
  assign Mem_wait_cnt = '0;
  assign Flush_cnt    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_detection_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_hazard_detection_unit
// Brief    : Directed self-checking bench for hazard_detection_unit
//            (MEM_TIMEOUT=4, CNT_W=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_hazard_detection_unit;

  localparam int c_CNT_W = 4;
`ifdef HAZARD_PERF_EN
  localparam bit c_PERF = 1'b1;
`else
  localparam bit c_PERF = 1'b0;
`endif

  // Control vector order: {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, Bubble_IDEX, Flush_IFID}
  localparam logic [5:0] c_CTL_RUN    = 6'b111100;
  localparam logic [5:0] c_CTL_STALL  = 6'b001110;
  localparam logic [5:0] c_CTL_FLUSH  = 6'b111111;
  localparam logic [5:0] c_CTL_FREEZE = 6'b000000;

  logic CLK = 1'b0;
  logic RESET;
  logic [4:0] Rs1_ID, Rs2_ID, Rd_EX;
  logic Uses_rs1_ID, Uses_rs2_ID, MemRead_EX, Branch_taken_EX, MemReq_MEM, Mem_ready;
  logic PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, Bubble_IDEX, Flush_IFID, Mem_timeout;
  logic [c_CNT_W-1:0] Load_use_cnt, Mem_wait_cnt, Flush_cnt;
  logic [5:0] w_ctl;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_detection_unit #(
    .MEM_TIMEOUT (4),
    .CNT_W       (c_CNT_W)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .Rs1_ID          (Rs1_ID),
    .Rs2_ID          (Rs2_ID),
    .Uses_rs1_ID     (Uses_rs1_ID),
    .Uses_rs2_ID     (Uses_rs2_ID),
    .Rd_EX           (Rd_EX),
    .MemRead_EX      (MemRead_EX),
    .Branch_taken_EX (Branch_taken_EX),
    .MemReq_MEM      (MemReq_MEM),
    .Mem_ready       (Mem_ready),
    .PCWrite         (PCWrite),
    .IFIDWrite       (IFIDWrite),
    .IDEXWrite       (IDEXWrite),
    .EXMEMWrite      (EXMEMWrite),
    .Bubble_IDEX     (Bubble_IDEX),
    .Flush_IFID      (Flush_IFID),
    .Mem_timeout     (Mem_timeout),
    .Load_use_cnt    (Load_use_cnt),
    .Mem_wait_cnt    (Mem_wait_cnt),
    .Flush_cnt       (Flush_cnt)
  );

  assign w_ctl = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, Bubble_IDEX, Flush_IFID};

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counter expectation: the modelled value when counters exist, else zero.
  function automatic logic [31:0] perf(input int v);
    return c_PERF ? 32'(v) : 32'd0;
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1_ID = 5'd0; Rs2_ID = 5'd0; Rd_EX = 5'd0;
    Uses_rs1_ID = 1'b0; Uses_rs2_ID = 1'b0; MemRead_EX = 1'b0;
    Branch_taken_EX = 1'b0; MemReq_MEM = 1'b0; Mem_ready = 1'b0;
  endtask

  initial begin
    clear_inputs();
    RESET = 1'b1;
    #1;
    check_eq("reset_ctl", 32'(w_ctl), 32'(c_CTL_RUN));
    check_eq("reset_timeout", 32'(Mem_timeout), 32'd0);
    check_eq("reset_cnt", 32'({Load_use_cnt, Mem_wait_cnt, Flush_cnt}), 32'd0);
    tick(); tick();
    RESET = 1'b0;
    tick();

    // Load-use stall on rs1, released by the bubble (Rd_EX=x0)
    MemRead_EX = 1'b1; Rd_EX = 5'd5; Rs1_ID = 5'd5; Uses_rs1_ID = 1'b1;
    #1 check_eq("lu_stall", 32'(w_ctl), 32'(c_CTL_STALL));
    tick();
    Rd_EX = 5'd0;
    #1 check_eq("lu_release", 32'(w_ctl), 32'(c_CTL_RUN));
    check_eq("lu_cnt1", 32'(Load_use_cnt), perf(1));

    // x0 destination never stalls
    Rs1_ID = 5'd0;
    #1 check_eq("x0_filter", 32'(w_ctl), 32'(c_CTL_RUN));
    tick();
    // unused rs2 never stalls
    Uses_rs1_ID = 1'b0; Rd_EX = 5'd7; Rs2_ID = 5'd7; Uses_rs2_ID = 1'b0;
    #1 check_eq("unused_rs2", 32'(w_ctl), 32'(c_CTL_RUN));
    tick();
    // used rs2 stalls
    Uses_rs2_ID = 1'b1;
    #1 check_eq("rs2_stall", 32'(w_ctl), 32'(c_CTL_STALL));
    tick();
    // matching register but not a load
    MemRead_EX = 1'b0;
    #1 check_eq("no_load", 32'(w_ctl), 32'(c_CTL_RUN));
    check_eq("lu_cnt2", 32'(Load_use_cnt), perf(2));

    // Branch outranks a pending load-use match
    MemRead_EX = 1'b1; Branch_taken_EX = 1'b1;
    #1 check_eq("br_priority", 32'(w_ctl), 32'(c_CTL_FLUSH));
    tick();
    check_eq("br_flush_cnt", 32'(Flush_cnt), perf(1));
    check_eq("br_lu_cnt", 32'(Load_use_cnt), perf(2));

    // Memory wait holds a taken branch for 3 cycles, acted on at release
    clear_inputs();
    Branch_taken_EX = 1'b1; MemReq_MEM = 1'b1; Mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq($sformatf("wait_freeze%0d", i), 32'(w_ctl), 32'(c_CTL_FREEZE));
      tick();
    end
    Mem_ready = 1'b1;
    #1 check_eq("wait_release", 32'(w_ctl), 32'(c_CTL_FLUSH));
    tick();
    check_eq("wait_cnt3", 32'(Mem_wait_cnt), perf(3));
    check_eq("wait_flush_cnt", 32'(Flush_cnt), perf(2));

    // Timeout after 4 consecutive wait cycles
    clear_inputs();
    #1 check_eq("pre_timeout_run", 32'(w_ctl), 32'(c_CTL_RUN));
    tick();
    MemReq_MEM = 1'b1; Mem_ready = 1'b0;
    tick(); tick(); tick();
    check_eq("timeout_not_yet", 32'(Mem_timeout), 32'd0);
    tick();
    check_eq("timeout_set", 32'(Mem_timeout), 32'd1);
    check_eq("timeout_wait_cnt", 32'(Mem_wait_cnt), perf(7));
    Mem_ready = 1'b1;
    #1 check_eq("error_frozen", 32'(w_ctl), 32'(c_CTL_FREEZE));
    tick();
    MemReq_MEM = 1'b0;
    tick();
    check_eq("error_sticky", 32'(Mem_timeout), 32'd1);
    check_eq("error_still_frozen", 32'(w_ctl), 32'(c_CTL_FREEZE));
    // asynchronous reset away from any clock edge
    #2 RESET = 1'b1;
    #1 check_eq("async_rst_ctl", 32'(w_ctl), 32'(c_CTL_RUN));
    check_eq("async_rst_timeout", 32'(Mem_timeout), 32'd0);
    check_eq("async_rst_cnt", 32'({Load_use_cnt, Mem_wait_cnt, Flush_cnt}), 32'd0);
    tick();
    RESET = 1'b0;
    tick();

    // 20 load-use stalls saturate a 4-bit counter at 15
    clear_inputs();
    MemRead_EX = 1'b1; Rd_EX = 5'd3; Rs1_ID = 5'd3; Uses_rs1_ID = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check_eq("sat_ctl", 32'(w_ctl), 32'(c_CTL_STALL));
    check_eq("sat_lu_cnt", 32'(Load_use_cnt), perf(15));
    check_eq("sat_other_cnt", 32'({Mem_wait_cnt, Flush_cnt}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
